march_c_bist: RTL and testbench

Built-in self-test controller that runs the March C- algorithm against the 64×8 bit-maskable single-port SRAM and checks every read. It sits directly upstream of the memory, drives its write enable, mask, address and data, and consumes its registered read data one cycle after each read is issued. It reports pass/fail, an error count and the first failing location.

---
 rtl/march_pkg.sv | 24 ++
 rtl/march_cmp.sv | 77 +++++++
 rtl/march_c_bist.sv | 121 ++++++++++++
 tb/tb_march_c_bist.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/march_pkg.sv
// march_pkg: shared state encoding and March C- element table for the BIST controller
package march_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam int NUM_ELEM = 6;

   // Bit e of each table describes element e; bits 6-7 pad the 3-bit element index
   localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
   localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
   localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;
   localparam logic [7:0] ELEM_RD_VAL = 8'b0001_0100;
   localparam logic [7:0] ELEM_WR_VAL = 8'b0000_1010;

   function automatic logic [1:0] elem_ops(input logic [2:0] e);
      return {1'b0, ELEM_HAS_RD[e]} + {1'b0, ELEM_HAS_WR[e]};
   endfunction

   // Two-op elements read first then write; single-op elements do whichever op they own
   function automatic logic op_is_write(input logic [2:0] e, input logic op);
      return op || !ELEM_HAS_RD[e];
   endfunction

endpackage

// File: rtl/march_cmp.sv
// march_cmp: one-stage read compare with error counter and first-failure capture
module march_cmp
   import march_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int ERR_W  = ADDR_W + 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clr,
   input  logic              i_iss_valid,
   input  logic [DATA_W-1:0] i_iss_exp,
   input  logic [ADDR_W-1:0] i_iss_addr,
   input  logic [2:0]        i_iss_elem,
   input  logic [DATA_W-1:0] i_mem_data,
   output logic [ERR_W-1:0]  o_err_count,
   output logic              o_fail_valid,
   output logic [2:0]        o_fail_elem,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [DATA_W-1:0] o_fail_exp,
   output logic [DATA_W-1:0] o_fail_act
);

   logic              r_vld;
   logic [DATA_W-1:0] r_exp;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_elem;
   logic [ERR_W-1:0]  r_err;
   logic              r_fv;
   logic [2:0]        r_fe;
   logic [ADDR_W-1:0] r_fa;
   logic [DATA_W-1:0] r_fx;
   logic [DATA_W-1:0] r_fy;
   logic              w_mis;

   assign w_mis = r_vld && (i_mem_data != r_exp);

   // Hold the issued read for one cycle, then score it against the returned word
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst || i_clr) begin
         r_vld  <= 1'b0;
         r_exp  <= '0;
         r_addr <= '0;
         r_elem <= '0;
         r_err  <= '0;
         r_fv   <= 1'b0;
         r_fe   <= '0;
         r_fa   <= '0;
         r_fx   <= '0;
         r_fy   <= '0;
      end else begin
         r_vld  <= i_iss_valid;
         r_exp  <= i_iss_exp;
         r_addr <= i_iss_addr;
         r_elem <= i_iss_elem;
         if (w_mis) begin
            r_err <= r_err + ERR_W'(1);
            if (!r_fv) begin
               r_fv <= 1'b1;
               r_fe <= r_elem;
               r_fa <= r_addr;
               r_fx <= r_exp;
               r_fy <= i_mem_data;
            end
         end
      end
   end

   assign o_err_count  = r_err;
   assign o_fail_valid = r_fv;
   assign o_fail_elem  = r_fe;
   assign o_fail_addr  = r_fa;
   assign o_fail_exp   = r_fx;
   assign o_fail_act   = r_fy;

endmodule

// File: rtl/march_c_bist.sv
// march_c_bist: March C- BIST sequencer driving a single-port SRAM and scoring every read
module march_c_bist
   import march_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int ERR_W  = ADDR_W + 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ERR_W-1:0]  o_err_count,
   output logic              o_fail_valid,
   output logic [2:0]        o_fail_elem,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [DATA_W-1:0] o_fail_exp,
   output logic [DATA_W-1:0] o_fail_act,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_we_mask,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_data_in,
   input  logic [DATA_W-1:0] i_mem_data_out
);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_elem, w_elem_nxt, w_elem_inc;
   logic              r_op, w_op_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic              r_we, w_we_nxt;
   logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
   logic              w_start_acc, w_last_op, w_term, w_iss;
   logic [ERR_W-1:0]  w_err;

   // Walk element/op/address; the memory-side outputs are precomputed for the coming op
   always_comb begin
      w_start_acc = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
      w_term      = ELEM_DOWN[r_elem] ? (r_addr == '0) : (r_addr == '1);
      w_last_op   = (elem_ops(r_elem) != 2'd2) || r_op;
      w_elem_inc  = r_elem + 3'd1;
      w_state_nxt = r_state;
      w_elem_nxt  = '0;
      w_op_nxt    = 1'b0;
      w_addr_nxt  = '0;
      if (w_start_acc)
         w_state_nxt = ST_RUN;
      else if (r_state == ST_RUN) begin
         w_elem_nxt = r_elem;
         w_addr_nxt = r_addr;
         if (!w_last_op)
            w_op_nxt = 1'b1;
         else if (!w_term)
            w_addr_nxt = ELEM_DOWN[r_elem] ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
         else if (r_elem == 3'(NUM_ELEM - 1)) begin
            w_state_nxt = ST_DRAIN;
            w_elem_nxt  = '0;
            w_addr_nxt  = '0;
         end else begin
            w_elem_nxt = w_elem_inc;
            w_addr_nxt = ELEM_DOWN[w_elem_inc] ? '1 : '0;
         end
      end else if (r_state == ST_DRAIN)
         w_state_nxt = ST_DONE;
      w_we_nxt    = (w_state_nxt == ST_RUN) && op_is_write(w_elem_nxt, w_op_nxt);
      w_wdata_nxt = w_we_nxt ? {DATA_W{ELEM_WR_VAL[w_elem_nxt]}} : '0;
   end

   // Sequencer state and registered memory-side outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_elem  <= '0;
         r_op    <= 1'b0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_elem  <= w_elem_nxt;
         r_op    <= w_op_nxt;
         r_addr  <= w_addr_nxt;
         r_we    <= w_we_nxt;
         r_wdata <= w_wdata_nxt;
      end
   end

   assign w_iss = (r_state == ST_RUN) && !r_we;

   march_cmp #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .ERR_W (ERR_W)
   ) u_cmp (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (w_start_acc),
      .i_iss_valid (w_iss),
      .i_iss_exp   ({DATA_W{ELEM_RD_VAL[r_elem]}}),
      .i_iss_addr  (r_addr),
      .i_iss_elem  (r_elem),
      .i_mem_data  (i_mem_data_out),
      .o_err_count (w_err),
      .o_fail_valid(o_fail_valid),
      .o_fail_elem (o_fail_elem),
      .o_fail_addr (o_fail_addr),
      .o_fail_exp  (o_fail_exp),
      .o_fail_act  (o_fail_act)
   );

   assign o_busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign o_done        = (r_state == ST_DONE);
   assign o_pass        = o_done && (w_err == '0);
   assign o_err_count   = w_err;
   assign o_mem_we      = r_we;
   assign o_mem_we_mask = {DATA_W{r_we}};
   assign o_mem_addr    = r_addr;
   assign o_mem_data_in = r_wdata;

endmodule

// File: tb/tb_march_c_bist.sv
// tb_march_c_bist: faulty-SRAM environment plus algorithmic March C- reference
module tb_march_c_bist;

   localparam int N = 64;
   localparam int NOPS = 10 * N;

   typedef struct packed {
      logic       we;
      logic [5:0] addr;
      logic [7:0] data;
   } op_t;

   logic       clk, rst, start;
   logic       busy, done, pass_o, fv, we;
   logic [8:0] err;
   logic [2:0] fe;
   logic [5:0] fa, addr;
   logic [7:0] fx, fy, mask, din, dout;

   march_c_bist dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_done(done), .o_pass(pass_o), .o_err_count(err),
      .o_fail_valid(fv), .o_fail_elem(fe), .o_fail_addr(fa),
      .o_fail_exp(fx), .o_fail_act(fy),
      .o_mem_we(we), .o_mem_we_mask(mask), .o_mem_addr(addr),
      .o_mem_data_in(din), .i_mem_data_out(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // fault configuration shared by the SRAM environment and the reference
   bit stk_en, cpl_en;
   int stk_addr, stk_bit, cpl_src, cpl_dst;
   bit stk_val;

   // March C- written as data: -1 means the element has no such op
   int rdv[6] = '{-1, 0, 1, 0, 1, 0};
   int wrv[6] = '{0, 1, 0, 1, 0, -1};
   bit dnv[6] = '{0, 0, 0, 1, 1, 0};

   int total = 0, bad = 0, cyc = 0, nw = 0;
   bit running = 0;
   op_t ops[$];
   int r_err;
   bit r_fv;
   int r_fe, r_fa, r_fx, r_fy;

   // faulty 64x8 SRAM with registered read
   logic [7:0] mem [N];
   always @(posedge clk) begin
      logic [7:0] v;
      if (we) begin
         mem[addr] <= (mem[addr] & ~mask) | (din & mask);
         if (cpl_en && int'(addr) == cpl_src) mem[cpl_dst] <= (mem[cpl_dst] & ~mask) | (din & mask);
      end
      v = mem[addr];
      if (stk_en && int'(addr) == stk_addr) v[stk_bit] = stk_val;
      dout <= v;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic build_ref();
      logic [7:0] m [N];
      logic [7:0] v, x;
      int a;
      op_t o;
      ops.delete();
      r_err = 0; r_fv = 0; r_fe = 0; r_fa = 0; r_fx = 0; r_fy = 0;
      for (int e = 0; e < 6; e++)
         for (int i = 0; i < N; i++) begin
            a = dnv[e] ? N - 1 - i : i;
            if (rdv[e] >= 0) begin
               x = (rdv[e] == 1) ? 8'hFF : 8'h00;
               v = m[a];
               if (stk_en && a == stk_addr) v[stk_bit] = stk_val;
               o.we = 1'b0; o.addr = 6'(a); o.data = 8'h00;
               ops.push_back(o);
               if (v != x) begin
                  if (!r_fv) begin r_fv = 1; r_fe = e; r_fa = a; r_fx = x; r_fy = v; end
                  r_err++;
               end
            end
            if (wrv[e] >= 0) begin
               x = (wrv[e] == 1) ? 8'hFF : 8'h00;
               m[a] = x;
               if (cpl_en && a == cpl_src) m[cpl_dst] = x;
               o.we = 1'b1; o.addr = 6'(a); o.data = x;
               ops.push_back(o);
            end
         end
   endtask

   // per-cycle compare against the reference op stream and end-of-run results
   always @(negedge clk) begin
      if (running) begin
         cyc++;
         if (cyc == 1) begin
            chk("clr_err", err, 0);
            chk("clr_fv", fv, 0);
            chk("clr_done", done, 0);
            chk("clr_pass", pass_o, 0);
         end
         if (cyc <= NOPS) begin
            chk("busy", busy, 1);
            chk("we", we, ops[cyc-1].we);
            chk("mask", mask, {8{ops[cyc-1].we}});
            chk("addr", addr, ops[cyc-1].addr);
            if (ops[cyc-1].we) chk("wdata", din, ops[cyc-1].data);
            if (we) nw++;
         end else if (cyc == NOPS + 1) begin
            chk("drain_busy", busy, 1);
            chk("drain_done", done, 0);
            chk("drain_we", we, 0);
         end else begin
            chk("end_busy", busy, 0);
            chk("end_done", done, 1);
            chk("end_pass", pass_o, (r_err == 0) ? 1 : 0);
            chk("end_err", err, r_err);
            chk("end_fv", fv, r_fv);
            chk("end_fe", fe, r_fe);
            chk("end_fa", fa, r_fa);
            chk("end_fx", fx, r_fx);
            chk("end_fy", fy, r_fy);
            chk("end_addr", addr, 0);
            running = 0;
         end
      end
   end

   task automatic chk_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_o, 0);
      chk("rst_we", we, 0);
      chk("rst_mask", mask, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_err", err, 0);
      chk("rst_fv", fv, 0);
      chk("rst_fe", fe, 0);
      chk("rst_fa", fa, 0);
      chk("rst_fx", fx, 0);
      chk("rst_fy", fy, 0);
   endtask

   // start a run; pulse start again in cycle sp_at, assert reset in cycle rst_at
   task automatic run_test(input int sp_at, input int rst_at);
      build_ref();
      nw = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      running = 1;
      for (int k = 1; k <= 700 && running; k++) begin
         start = (k == sp_at);
         if (k == rst_at) begin
            chk("pre_rst_we", we, 1);
            chk("pre_rst_busy", busy, 1);
            running = 0;
            rst = 1'b1;
            #1;
            chk_reset();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      if (running) begin
         total++; bad++;
         $display("FAIL timeout cyc=%0d got=running want=done", cyc);
         running = 0;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      stk_en = 0; cpl_en = 0; stk_addr = 0; stk_bit = 0; stk_val = 0; cpl_src = 0; cpl_dst = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      rst = 1'b0;

      // fault-free run, then pin the reference op stream by hand
      run_test(0, 0);
      chk("nw", nw, 320);
      chk("ff_pass", pass_o, 1);
      chk("m_len", ops.size(), 640);
      chk("m_op1", ops[0], {1'b1, 6'd0, 8'h00});
      chk("m_op65", ops[64], {1'b0, 6'd0, 8'h00});
      chk("m_op66", ops[65], {1'b1, 6'd0, 8'hFF});
      chk("m_op321", ops[320], {1'b0, 6'd63, 8'h00});
      chk("m_op640", ops[639], {1'b0, 6'd63, 8'h00});

      // bit 3 of addr 17 stuck at 0
      stk_en = 1; stk_addr = 17; stk_bit = 3; stk_val = 0;
      run_test(0, 0);
      chk("sa_err", err, 2);
      chk("sa_fe", fe, 2);
      chk("sa_fa", fa, 17);
      chk("sa_fx", fx, 8'hFF);
      chk("sa_fy", fy, 8'hF7);
      chk("sa_pass", pass_o, 0);
      stk_en = 0;

      // restart from a failing DONE with a coupling fault 5 -> 6
      cpl_en = 1; cpl_src = 5; cpl_dst = 6;
      run_test(0, 0);
      chk("cf_err", err, 2);
      chk("cf_fe", fe, 1);
      chk("cf_fa", fa, 6);
      chk("cf_fx", fx, 8'h00);
      chk("cf_fy", fy, 8'hFF);
      cpl_en = 0;

      // start mid-run is ignored; completion still at cycle 642
      run_test(100, 0);
      chk("sp_pass", pass_o, 1);

      // reset in cycle 300, then a clean run
      run_test(0, 300);
      run_test(0, 0);
      chk("post_rst_pass", pass_o, 1);

      // randomized faults and stray start pulses
      for (int r = 0; r < 5; r++) begin
         int mode;
         mode = $urandom_range(0, 2);
         stk_en = (mode == 1); cpl_en = (mode == 2);
         stk_addr = $urandom_range(0, N - 1);
         stk_bit = $urandom_range(0, 7);
         stk_val = 1'($urandom_range(0, 1));
         cpl_src = $urandom_range(0, N - 1);
         cpl_dst = (cpl_src + $urandom_range(1, N - 1)) % N;
         run_test($urandom_range(1, NOPS + 1), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
